merge_4_rr: RTL and testbench
=============================

# merge_4_rr

Clocked 4-to-1 round-robin merge stage that sits directly downstream of `split_4` in the router datapath. It recombines the four split output channels (11-bit flits) onto one output channel. Each forwarded flit carries a 2-bit source tag identifying the input it came from. The block has a single registered output slot with valid/ready flow control, so it can feed a synchronous link or a cosim wrapper without combinational paths from output back to input data.

## Interface
- `W`, 11, flit data width in bits (the `split_4` payload width)
- `CLK`  input  1  rising-edge clock
- `_RESET`  input  1  synchronous, active-low reset, sampled on rising `CLK`
- `in0_data` .. `in3_data`  input  W each  flit payload per input channel
- `in0_valid` .. `in3_valid`  input  1 each  input holds a flit
- `in0_ready` .. `in3_ready`  output  1 each  flit on this input is consumed this cycle
- `out_data`  output  W  registered flit payload
- `out_src`  output  2  registered index of the input that supplied `out_data`
- `out_valid`  output  1  output slot holds a flit
- `out_ready`  input  1  downstream accepts the flit this cycle

## Operation
- State consists of:
  - the output slot: `out_data`, `out_src`, `out_valid`
  - a 2-bit round-robin pointer `ptr`, the highest-priority input for the next grant
- Slot load enable: `load = !out_valid | out_ready`. The slot is empty, or it is being drained this cycle.
- Arbitration is combinational each cycle:
  - Scan inputs in the order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - The first input with `valid=1` is granted.
  - No valid input means no grant.
- `inK_ready = load & grant[K]`. At most one `ready` is high per cycle. `ready` never goes high for an input whose `valid` is low.
- On a rising edge with `load=1` and a grant to input K:
  - `out_data` <= `inK_data`
  - `out_src` <= K
  - `out_valid` <= 1
  - `ptr` <= K+1 (mod 4)
- On a rising edge with `load=1` and no grant:
  - `out_valid` <= 0
  - `out_data`, `out_src` and `ptr` hold.
- On a rising edge with `load=0` (slot full and stalled), all state holds.
- Stall rule: while `out_valid=1` and `out_ready=0`, `out_data` and `out_src` are stable.
- Inputs may present a flit and wait indefinitely. An input's `valid`/`data` must stay stable until its `ready` is seen; the block may rely on this.
- Fairness: with all four inputs continuously valid and `out_ready=1`, grants rotate 0,1,2,3,0… from reset. Any continuously valid input is granted within 4 loads.
- `ptr` advances only on a grant. Idle cycles do not move it.

## Timing
- Reset (`_RESET=0` at a rising edge) sets:
  - `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0
  - all `inK_ready`=0 for as long as `_RESET` is low; the ready terms are gated by `_RESET`.
- Reset mid-operation: a flit held in the slot is discarded. No input is acknowledged in the reset cycle.
- Latency: a flit accepted at edge N is visible on `out_*` after edge N and can be consumed by downstream in cycle N+1. Input-to-output latency is 1 cycle.
- Throughput is 1 flit/cycle when `out_ready` is held high. Simultaneous drain and load in the same cycle is required, with no bubble.
- `inK_ready` depends combinationally on `out_valid`, `out_ready`, all `inK_valid` and `ptr`.
- `out_*` are pure register outputs.
- Pointer wrap: a grant to input 3 sets `ptr`=0.

## Test plan
- **Reset:** hold `_RESET`=0 for 4 cycles with all inputs valid (`in0_data`=11'h005) -> `out_valid`=0, all `ready`=0. First edge after release loads 11'h005 with `out_src`=0.
- **Single input streaming:** `in2_valid`=1 with data 1,2,3…; `out_ready`=1 -> out sequence 1,2,3 with `out_src`=2, one per cycle, no gaps. `ptr` reads 3 after each grant.
- **Round-robin rotation:** all four inputs valid, with values 11'h100+K per input; `out_ready`=1 -> `out_src` sequence 0,1,2,3,0,1 on consecutive cycles. Data matches the source.
- **Backpressure:** slot full with `out_src`=1, data 11'h2AA; `out_ready`=0 for 5 cycles while inputs 0 and 3 are valid -> outputs stable, all `ready`=0. Then `out_ready`=1 -> same-cycle reload from input 3 (`ptr`=2 scans 2,3).
- **Idle pointer hold:** grant input 0, then 3 idle cycles, then inputs 0 and 1 valid together -> input 1 granted first. `out_valid` is 0 during the idle cycles after drain.
- **Reset mid-stall:** slot holds 11'h7FF with `out_ready`=0; assert `_RESET`=0 for one cycle -> `out_valid`=0, `ptr`=0, and the stalled flit is not delivered.

Source files
------------

// File: rtl/merge_4_rr.sv
// merge_4_rr: clocked 4-to-1 round-robin merge stage.
//
// Recombines four flit channels (one per split_4 output) onto a single
// registered output slot. Each forwarded flit is tagged with the index of
// the input that supplied it. The output slot refills in the same cycle it
// is drained, so a continuously ready downstream sees one flit per cycle.
//
// Ports:
//   CLK                  rising-edge clock
//   _RESET               synchronous active-low reset
//   inK_data  (K=0..3)   flit payload for input K
//   inK_valid (K=0..3)   input K holds a flit
//   inK_ready (K=0..3)   flit on input K is consumed this cycle
//   out_data             registered flit payload
//   out_src              registered index of the supplying input
//   out_valid            output slot holds a flit
//   out_ready            downstream accepts the slot contents this cycle
module merge_4_rr #(
  parameter int W = 11
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic [W-1:0] in1_data,
  input  logic [W-1:0] in2_data,
  input  logic [W-1:0] in3_data,
  input  logic         in0_valid,
  input  logic         in1_valid,
  input  logic         in2_valid,
  input  logic         in3_valid,
  output logic         in0_ready,
  output logic         in1_ready,
  output logic         in2_ready,
  output logic         in3_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_src,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] data_q, data_d;
  logic [1:0]   src_q, src_d;
  logic         vld_q, vld_d;
  logic [1:0]   ptr_q, ptr_d;

  logic [3:0]   valid_vec;
  logic [3:0]   grant;
  logic [1:0]   gidx;
  logic         found;
  logic         load;
  logic [W-1:0] gdata;

  assign valid_vec = {in3_valid, in2_valid, in1_valid, in0_valid};

  // Slot can take a new flit when empty or being drained this cycle.
  assign load = ~vld_q | out_ready;

  // Round-robin scan starting at ptr_q; the first valid input wins.
  always_comb begin
    logic [1:0] idx;
    grant = 4'b0000;
    gidx  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && valid_vec[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    gdata = in0_data;
    case (gidx)
      2'd0: gdata = in0_data;
      2'd1: gdata = in1_data;
      2'd2: gdata = in2_data;
      2'd3: gdata = in3_data;
      default: gdata = in0_data;
    endcase
  end

  // Acknowledges are suppressed while reset is held so no flit is lost.
  assign in0_ready = _RESET & load & grant[0];
  assign in1_ready = _RESET & load & grant[1];
  assign in2_ready = _RESET & load & grant[2];
  assign in3_ready = _RESET & load & grant[3];

  always_comb begin
    data_d = data_q;
    src_d  = src_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (load) begin
      if (found) begin
        data_d = gdata;
        src_d  = gidx;
        vld_d  = 1'b1;
        ptr_d  = gidx + 2'd1;
      end else begin
        // Pointer only advances on a grant; idle cycles leave it alone.
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      data_q <= '0;
      src_q  <= 2'd0;
      vld_q  <= 1'b0;
      ptr_q  <= 2'd0;
    end else begin
      data_q <= data_d;
      src_q  <= src_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_merge_4_rr.sv
module tb_merge_4_rr;

  localparam int W = 11;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d0, d1, d2, d3;
  logic         v0, v1, v2, v3;
  logic         r0, r1, r2, r3;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   rdy;

  int n_cmp = 0;
  int n_err = 0;

  merge_4_rr #(.W(W)) dut (
    .CLK       (clk),
    ._RESET    (rst_n),
    .in0_data  (d0),
    .in1_data  (d1),
    .in2_data  (d2),
    .in3_data  (d3),
    .in0_valid (v0),
    .in1_valid (v1),
    .in2_valid (v2),
    .in3_valid (v3),
    .in0_ready (r0),
    .in1_ready (r1),
    .in2_ready (r2),
    .in3_ready (r3),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign rdy = {r3, r2, r1, r0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; v2 = 0; v3 = 0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    out_ready = 1;
    idle_inputs();
    #1;

    // Reset held 4 cycles with all inputs valid
    v0 = 1; v1 = 1; v2 = 1; v3 = 1;
    d0 = 11'h005; d1 = 11'h006; d2 = 11'h007; d3 = 11'h008;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_ready_%0d", i), 32'(rdy), 32'h0);
      tick();
      check($sformatf("rst_valid_%0d", i), 32'(out_valid), 32'h0);
      check($sformatf("rst_data_%0d", i), 32'(out_data), 32'h0);
      check($sformatf("rst_src_%0d", i), 32'(out_src), 32'h0);
    end
    rst_n = 1;
    @(negedge clk);
    check("rel_ready", 32'(rdy), 32'h1);
    tick();
    check("rel_valid", 32'(out_valid), 32'h1);
    check("rel_data", 32'(out_data), 32'h005);
    check("rel_src", 32'(out_src), 32'h0);

    // Round-robin rotation from reset
    do_reset();
    v0 = 1; v1 = 1; v2 = 1; v3 = 1;
    d0 = 11'h100; d1 = 11'h101; d2 = 11'h102; d3 = 11'h103;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rr_ready_%0d", i), 32'(rdy), 32'(4'b0001 << (i % 4)));
      tick();
      check($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("rr_src_%0d", i), 32'(out_src), 32'(i % 4));
      check($sformatf("rr_data_%0d", i), 32'(out_data), 32'(11'h100 + (i % 4)));
    end

    // Single input streaming on input 2
    do_reset();
    v2 = 1;
    for (int k = 1; k <= 3; k++) begin
      d2 = 11'(k);
      @(negedge clk);
      check($sformatf("s2_ready_%0d", k), 32'(rdy), 32'h4);
      tick();
      check($sformatf("s2_valid_%0d", k), 32'(out_valid), 32'h1);
      check($sformatf("s2_data_%0d", k), 32'(out_data), 32'(k));
      check($sformatf("s2_src_%0d", k), 32'(out_src), 32'h2);
      check($sformatf("s2_ptr_%0d", k), 32'(dut.ptr_q), 32'h3);
    end

    // Backpressure: fill slot from input 1, then stall
    do_reset();
    out_ready = 0;
    v1 = 1; d1 = 11'h2AA;
    tick();
    check("bp_fill_src", 32'(out_src), 32'h1);
    check("bp_fill_data", 32'(out_data), 32'h2AA);
    v1 = 0; d1 = '0;
    v0 = 1; d0 = 11'h011;
    v3 = 1; d3 = 11'h033;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_ready_%0d", i), 32'(rdy), 32'h0);
      tick();
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("bp_data_%0d", i), 32'(out_data), 32'h2AA);
      check($sformatf("bp_src_%0d", i), 32'(out_src), 32'h1);
    end
    out_ready = 1;
    @(negedge clk);
    check("bp_rel_ready", 32'(rdy), 32'h8);
    tick();
    check("bp_rel_valid", 32'(out_valid), 32'h1);
    check("bp_rel_data", 32'(out_data), 32'h033);
    check("bp_rel_src", 32'(out_src), 32'h3);
    check("bp_rel_ptr", 32'(dut.ptr_q), 32'h0);

    // Idle cycles must not move the pointer
    do_reset();
    v0 = 1; d0 = 11'h00A;
    tick();
    check("idle_g0_src", 32'(out_src), 32'h0);
    check("idle_g0_data", 32'(out_data), 32'h00A);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_valid_%0d", i), 32'(out_valid), 32'h0);
      check($sformatf("idle_ptr_%0d", i), 32'(dut.ptr_q), 32'h1);
    end
    v0 = 1; d0 = 11'h00B;
    v1 = 1; d1 = 11'h00C;
    @(negedge clk);
    check("idle_ready", 32'(rdy), 32'h2);
    tick();
    check("idle_g1_src", 32'(out_src), 32'h1);
    check("idle_g1_data", 32'(out_data), 32'h00C);

    // Reset while a flit is stalled in the slot
    do_reset();
    out_ready = 0;
    v2 = 1; d2 = 11'h7FF;
    tick();
    check("ms_fill_data", 32'(out_data), 32'h7FF);
    check("ms_fill_valid", 32'(out_valid), 32'h1);
    idle_inputs();
    tick();
    check("ms_hold_data", 32'(out_data), 32'h7FF);
    rst_n = 0;
    out_ready = 1;
    v0 = 1; d0 = 11'h055;
    @(negedge clk);
    check("ms_rst_ready", 32'(rdy), 32'h0);
    tick();
    check("ms_rst_valid", 32'(out_valid), 32'h0);
    check("ms_rst_ptr", 32'(dut.ptr_q), 32'h0);
    check("ms_rst_data", 32'(out_data), 32'h0);
    rst_n = 1;
    idle_inputs();
    tick();
    check("ms_after_valid", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
